// File: rtl/axi_sram_slave.sv
// AXI responder backed by a word-addressed 32-bit RAM; one read and one write burst in flight.
// Optional ready/valid stall injection with `define AXI_SLV_STALL_EN.
module axi_sram_slave #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned ID_W       = 4,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic {RIdle, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  logic [31:0] mem_q [Depth];
  logic        stall;

`ifdef AXI_SLV_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge aclk) begin
    if (areset) lfsr_q <= STALL_SEED;
    else        lfsr_q <= lfsr_d;
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall = 1'b0;
`endif

  logic unused_in;
  assign unused_in = ^{arsize, awsize, wid, wlast, araddr[31:ADDR_W+2], araddr[1:0],
                       awaddr[31:ADDR_W+2], awaddr[1:0]};

  // ---------------- read channel ----------------
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, raddr_nxt, rd_idx;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic              rfixed_q, rfixed_d, rvalid_q, rvalid_d, rd_en;
  logic [31:0]       rdata_q;
  logic              ar_hs, r_hs;

  assign arready   = (r_state_q == RIdle) & ~areset & ~stall;
  assign rvalid    = rvalid_q & ~areset;
  assign rlast     = rvalid & (rcnt_q == rlen_q);
  assign rid       = areset ? '0 : rid_q;
  assign rdata     = areset ? '0 : rdata_q;
  assign rresp     = 2'b00;
  assign ar_hs     = arvalid & arready;
  assign r_hs      = rvalid & rready;
  assign raddr_nxt = rfixed_q ? raddr_q : raddr_q + 1'b1;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rfixed_d  = rfixed_q;
    rvalid_d  = rvalid_q;
    rd_en     = 1'b0;
    rd_idx    = raddr_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_state_d = RData;
          rid_d     = arid;
          raddr_d   = araddr[ADDR_W+1:2];
          rlen_d    = arlen;
          rcnt_d    = 8'd0;
          rfixed_d  = (arburst == 2'b00);
          rd_en     = 1'b1;
          rd_idx    = araddr[ADDR_W+1:2];
          rvalid_d  = 1'b1;
        end
      end
      RData: begin
        if (r_hs) begin
          if (rcnt_q == rlen_q) begin
            r_state_d = RIdle;
            rvalid_d  = 1'b0;
          end else begin
            raddr_d  = raddr_nxt;
            rcnt_d   = rcnt_q + 8'd1;
            rd_en    = ~stall;
            rd_idx   = raddr_nxt;
            rvalid_d = ~stall;
          end
        end else if (!rvalid_q && !stall) begin
          // Launch a beat that a stall cycle held back.
          rd_en    = 1'b1;
          rvalid_d = 1'b1;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= RIdle;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rfixed_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rfixed_q  <= rfixed_d;
      rvalid_q  <= rvalid_d;
      if (rd_en) rdata_q <= mem_q[rd_idx];
    end
  end

  // ---------------- write channel ----------------
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic              wfixed_q, wfixed_d;
  logic              aw_hs, w_hs;

  assign awready = (w_state_q == WIdle) & ~areset & ~stall;
  assign wready  = (w_state_q == WData) & ~areset & ~stall;
  assign bvalid  = (w_state_q == WResp) & ~areset;
  assign bid     = areset ? '0 : bid_q;
  assign bresp   = 2'b00;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wfixed_d  = wfixed_q;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          w_state_d = WData;
          bid_d     = awid;
          waddr_d   = awaddr[ADDR_W+1:2];
          wlen_d    = awlen;
          wcnt_d    = 8'd0;
          wfixed_d  = (awburst == 2'b00);
        end
      end
      WData: begin
        if (w_hs) begin
          waddr_d = wfixed_q ? waddr_q : waddr_q + 1'b1;
          wcnt_d  = wcnt_q + 8'd1;
          if (wcnt_q == wlen_q) w_state_d = WResp;
        end
      end
      WResp: begin
        if (bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= WIdle;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wfixed_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wfixed_q  <= wfixed_d;
    end
  end

  // RAM contents survive reset; a same-cycle read of this word sees the old value.
  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[waddr_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (default build, no stall injection).
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  arid = '0, rid, awid = '0, wid = '0, bid;
  logic [31:0] araddr = '0, rdata, awaddr = '0, wdata = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = 3'd2, awsize = 3'd2;
  logic [1:0]  arburst = 2'd1, awburst = 2'd1, rresp, bresp;
  logic        arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  axi_sram_slave dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] base,
                           input logic [3:0] strb);
    int waits;
    @(posedge aclk); #1;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    @(negedge aclk);
    waits = 0;
    while (!awready && waits < 50) begin @(negedge aclk); waits++; end
    check_eq("aw_wait", 32'(waits), 32'd0);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = base + 32'(i); wstrb = strb; wlast = (i == int'(len));
      @(negedge aclk);
      waits = 0;
      while (!wready && waits < 50) begin @(negedge aclk); waits++; end
      check_eq("w_wait", 32'(waits), 32'd0);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge aclk);
    waits = 0;
    while (!bvalid && waits < 50) begin @(negedge aclk); waits++; end
    check_eq("b_wait", 32'(waits), 32'd0);
    check_eq("bid", 32'(bid), 32'(id));
    check_eq("bresp", 32'(bresp), 32'd0);
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  // stall_beat < 0 disables the mid-burst rready drop.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] base, input bit incr,
                          input int stall_beat, input int stall_cycles);
    int waits;
    logic [31:0] exp;
    @(posedge aclk); #1;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1; rready = 1'b1;
    @(negedge aclk);
    waits = 0;
    while (!arready && waits < 50) begin @(negedge aclk); waits++; end
    check_eq("ar_wait", 32'(waits), 32'd0);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      exp = incr ? base + 32'(i) : base;
      @(negedge aclk);
      waits = 0;
      while (!rvalid && waits < 50) begin @(negedge aclk); waits++; end
      check_eq("r_wait", 32'(waits), 32'd0);
      check_eq("rdata", rdata, exp);
      check_eq("rlast", 32'(rlast), 32'(i == int'(len)));
      check_eq("rid", 32'(rid), 32'(id));
      check_eq("rresp", 32'(rresp), 32'd0);
      if (i == stall_beat) begin
        rready = 1'b0;
        for (int c = 0; c < stall_cycles; c++) begin
          @(negedge aclk);
          check_eq("stall_rvalid", 32'(rvalid), 32'd1);
          check_eq("stall_rdata", rdata, exp);
        end
        rready = 1'b1;
      end
      @(posedge aclk);
    end
    @(negedge aclk);
    check_eq("r_done", 32'(rvalid), 32'd0);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_arready", 32'(arready), 32'd0);
    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_wready", 32'(wready), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rlast", 32'(rlast), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_rid", 32'(rid), 32'd0);
    check_eq("rst_bid", 32'(bid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check_eq("post_rst_arready", 32'(arready), 32'd1);
    check_eq("post_rst_awready", 32'(awready), 32'd1);

    // Single write then single read.
    axi_write(4'h5, 32'h0000_0100, 8'd0, 2'd1, 32'h1122_3344, 4'hF);
    axi_read(4'h2, 32'h0000_0100, 8'd0, 2'd1, 32'h1122_3344, 1'b1, -1, 0);

    // INCR 4-beat write then line-refill read.
    axi_write(4'h1, 32'h0000_1C00, 8'd3, 2'd1, 32'hC0DE_0000, 4'hF);
    axi_read(4'h3, 32'h0000_1C00, 8'd3, 2'd1, 32'hC0DE_0000, 1'b1, -1, 0);

    // Partial strobe over a zeroed word.
    axi_write(4'h6, 32'h0000_0200, 8'd0, 2'd1, 32'h0000_0000, 4'hF);
    axi_write(4'h6, 32'h0000_0200, 8'd0, 2'd1, 32'hAABB_CCDD, 4'b0101);
    axi_read(4'h6, 32'h0000_0200, 8'd0, 2'd1, 32'h00BB_00DD, 1'b1, -1, 0);

    // FIXED burst repeats the same word.
    axi_read(4'h1, 32'h0000_1C04, 8'd1, 2'd0, 32'hC0DE_0001, 1'b0, -1, 0);

    // rready held low for 5 cycles on beat 2.
    axi_read(4'h3, 32'h0000_1C00, 8'd3, 2'd1, 32'hC0DE_0000, 1'b1, 1, 5);

    // W before AW is held off, then concurrent write and read bursts.
    @(posedge aclk); #1;
    wvalid = 1'b1; wdata = 32'h5566_0000; wstrb = 4'hF;
    @(negedge aclk);
    check_eq("w_before_aw", 32'(wready), 32'd0);
    fork
      axi_write(4'h7, 32'h0000_0300, 8'd1, 2'd1, 32'h5566_0000, 4'hF);
      axi_read(4'h8, 32'h0000_1C00, 8'd3, 2'd1, 32'hC0DE_0000, 1'b1, -1, 0);
    join
    axi_read(4'h7, 32'h0000_0300, 8'd1, 2'd1, 32'h5566_0000, 1'b1, -1, 0);

    // Reset pulse during beat 2 of a 4-beat read.
    @(posedge aclk); #1;
    arid = 4'h9; araddr = 32'h0000_1C00; arlen = 8'd3; arburst = 2'd1; arvalid = 1'b1;
    rready = 1'b1;
    @(negedge aclk);
    check_eq("rr_arready", 32'(arready), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk);
    check_eq("rr_beat1", rdata, 32'hC0DE_0000);
    @(posedge aclk);
    @(negedge aclk);
    check_eq("rr_beat2_valid", 32'(rvalid), 32'd1);
    check_eq("rr_beat2", rdata, 32'hC0DE_0001);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0; rready = 1'b0;
    @(negedge aclk);
    check_eq("rr_rvalid_off", 32'(rvalid), 32'd0);
    check_eq("rr_arready_back", 32'(arready), 32'd1);
    @(negedge aclk);
    check_eq("rr_no_more_beats", 32'(rvalid), 32'd0);
    axi_read(4'hA, 32'h0000_0100, 8'd0, 2'd1, 32'h1122_3344, 1'b1, -1, 0);
    axi_read(4'hB, 32'h0000_1C00, 8'd3, 2'd1, 32'hC0DE_0000, 1'b1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
